// File: rtl/chiptest_pkg.sv
// Shared types and defaults for the chip-test stimulus/measurement blocks.
// Square-wave generator state encoding and sizing live here.
package chiptest_pkg;

  localparam int CNT_W_DEF   = 13;
  localparam int BURST_W_DEF = 8;
  localparam int MIN_PERIOD  = 2;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } wg_state_t;

endpackage

// File: rtl/wave_gen_if.sv
// Configuration handshake bundle for wave_gen.
// Master offers period/high/burst, slave answers with cfg_ready.
interface wave_gen_if #(
  parameter int CNT_W   = chiptest_pkg::CNT_W_DEF,
  parameter int BURST_W = chiptest_pkg::BURST_W_DEF
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_high;
  logic [BURST_W-1:0] cfg_burst;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_high,
    output cfg_burst,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_high,
    input  cfg_burst,
    output cfg_ready
  );

endinterface

// File: rtl/wg_cfg_shadow.sv
// Pending-config shadow for wave_gen: handshake, sanitiser, pend flag.
// The FSM pulses load_i when it copies the shadow into the active set.
module wg_cfg_shadow
  import chiptest_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               Clock,
  input  logic               nReset,
  wave_gen_if.slave          cfg,
  input  logic               load_i,
  output logic               pend_o,
  output logic [CNT_W-1:0]   p_o,
  output logic [CNT_W-1:0]   h_o,
  output logic [BURST_W-1:0] b_o
);

  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic [BURST_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]   p_san;
  logic [CNT_W-1:0]   h_san;
  logic               xfer;

  assign cfg.cfg_ready = !pend_q;
  assign xfer          = cfg.cfg_valid && !pend_q;

  // Guarantee at least one high and one low cycle per period.
  always_comb begin
    p_san = cfg.cfg_period;
    if (p_san < CNT_W'(MIN_PERIOD)) begin
      p_san = CNT_W'(MIN_PERIOD);
    end
    h_san = cfg.cfg_high;
    if (h_san == '0) begin
      h_san = CNT_W'(1);
    end
    if (h_san >= p_san) begin
      h_san = p_san - CNT_W'(1);
    end
  end

  always_comb begin
    pend_d = pend_q;
    p_d    = p_q;
    h_d    = h_q;
    b_d    = b_q;
    if (xfer) begin
      pend_d = 1'b1;
      p_d    = p_san;
      h_d    = h_san;
      b_d    = cfg.cfg_burst;
    end else if (load_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pend_q <= 1'b0;
      p_q    <= '0;
      h_q    <= '0;
      b_q    <= '0;
    end else begin
      pend_q <= pend_d;
      p_q    <= p_d;
      h_q    <= h_d;
      b_q    <= b_d;
    end
  end

  assign pend_o = pend_q;
  assign p_o    = p_q;
  assign h_o    = h_q;
  assign b_o    = b_q;

endmodule

// File: rtl/wave_gen.sv
// Programmable square-wave generator with glitch-free reconfiguration
// at period boundaries and optional burst length.
module wave_gen
  import chiptest_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic      Clock,
  input  logic      nReset,
  wave_gen_if.slave cfg,
  input  logic      enable,
  output logic      out_wave,
  output logic      edge_pulse,
  output logic      busy,
  output logic      done
);

  wg_state_t          state_q, state_d;
  logic [CNT_W-1:0]   ph_q, ph_d;
  logic [BURST_W-1:0] per_q, per_d;
  logic [CNT_W-1:0]   pa_q, ha_q;
  logic [BURST_W-1:0] ba_q;
  logic               loaded_q;
  logic               out_q, edge_q, done_q, busy_q;
  logic               edge_d, done_d;
  logic               load;
  logic               pend;
  logic [CNT_W-1:0]   p_s, h_s;
  logic [BURST_W-1:0] b_s;

  wg_cfg_shadow #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) u_shadow (
    .Clock  (Clock),
    .nReset (nReset),
    .cfg    (cfg),
    .load_i (load),
    .pend_o (pend),
    .p_o    (p_s),
    .h_o    (h_s),
    .b_o    (b_s)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    per_d   = per_q;
    load    = 1'b0;
    edge_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        load = pend;
        if (enable && loaded_q) begin
          state_d = HIGH;
          ph_d    = '0;
          per_d   = '0;
          edge_d  = 1'b1;
        end
      end
      HIGH: begin
        ph_d = ph_q + CNT_W'(1);
        if (ph_q == ha_q - CNT_W'(1)) begin
          state_d = LOW;
        end
      end
      LOW: begin
        ph_d = ph_q + CNT_W'(1);
        if (ph_q == pa_q - CNT_W'(1)) begin
          per_d = per_q + BURST_W'(1);
          // Burst end and stop request collapse into one done pulse.
          if ((ba_q != '0 && per_d == ba_q) || !enable) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = HIGH;
            ph_d    = '0;
            load    = pend;
            edge_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      per_q    <= '0;
      out_q    <= 1'b0;
      edge_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      per_q    <= per_d;
      out_q    <= (state_d == HIGH);
      edge_q   <= edge_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pa_q     <= '0;
      ha_q     <= '0;
      ba_q     <= '0;
      loaded_q <= 1'b0;
    end else if (load) begin
      pa_q     <= p_s;
      ha_q     <= h_s;
      ba_q     <= b_s;
      loaded_q <= 1'b1;
    end
  end

  assign out_wave   = out_q;
  assign edge_pulse = edge_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_wave_gen.sv
// Directed + randomized bench for wave_gen against a period/high-time
// model of the expected waveform.
module tb_wave_gen;

  logic Clock;
  logic nReset;
  logic enable;
  logic out_wave;
  logic edge_pulse;
  logic busy;
  logic done;

  int n_chk;
  int n_fail;

  wave_gen_if #(.CNT_W(13), .BURST_W(8)) bus ();

  wave_gen #(.CNT_W(13), .BURST_W(8)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .cfg        (bus),
    .enable     (enable),
    .out_wave   (out_wave),
    .edge_pulse (edge_pulse),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference rule: P>=2, 1<=H<=P-1.
  task automatic san(input int p, input int h, output int ps, output int hs);
    ps = (p < 2) ? 2 : p;
    hs = (h == 0) ? 1 : h;
    if (hs >= ps) hs = ps - 1;
  endtask

  // Cycle k of a running waveform: high for the first h cycles of each
  // p-cycle period, rising edge at the start of each period.
  task automatic span(input string tag, input int p, input int h,
                      input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      chk({tag, "_out"}, out_wave, (k % p) < h);
      chk({tag, "_edge"}, edge_pulse, (k % p) == 0);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_done"}, done, 1'b0);
      tick();
    end
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_out"}, out_wave, 1'b0);
      chk({tag, "_edge"}, edge_pulse, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      tick();
    end
  endtask

  task automatic load_cfg(input int p, input int h, input int b);
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 13'(p);
    bus.cfg_high   = 13'(h);
    bus.cfg_burst  = 8'(b);
    tick();
    bus.cfg_valid  = 1'b0;
    chk("cfg_pend_ready", bus.cfg_ready, 1'b0);
    tick();
    chk("cfg_idle_ready", bus.cfg_ready, 1'b1);
  endtask

  task automatic end_check(input string tag);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_out"}, out_wave, 1'b0);
  endtask

  int ps, hs, pr, hr, br, off, h8, last, meas;

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    nReset         = 1'b0;
    enable         = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_high   = '0;
    bus.cfg_burst  = '0;
    repeat (2) tick();
    chk("rst_out", out_wave, 1'b0);
    chk("rst_edge", edge_pulse, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.cfg_ready, 1'b1);
    nReset = 1'b1;
    tick();

    enable = 1'b1;
    quiet("noload", 3);
    enable = 1'b0;

    load_cfg(10, 5, 0);
    enable = 1'b1;
    tick();
    span("p10", 10, 5, 0, 30);

    off = int'($urandom_range(1, 4));
    span("p10a", 10, 5, 0, off);
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 13'd6;
    bus.cfg_high   = 13'd2;
    bus.cfg_burst  = 8'd0;
    span("p10b", 10, 5, off, off + 1);
    bus.cfg_valid  = 1'b0;
    chk("mid_ready_low", bus.cfg_ready, 1'b0);
    span("p10c", 10, 5, off + 1, 10);
    chk("mid_ready_back", bus.cfg_ready, 1'b1);
    span("p6", 6, 2, 0, 15);
    enable = 1'b0;
    span("p6stop", 6, 2, 15, 18);
    end_check("p6end");
    tick();
    quiet("p6q", 8);

    h8 = int'($urandom_range(1, 7));
    load_cfg(8, h8, 0);
    enable = 1'b1;
    tick();
    span("p8a", 8, h8, 0, 3);
    enable = 1'b0;
    span("p8b", 8, h8, 3, 8);
    end_check("p8end");
    tick();
    quiet("p8q", 12);

    load_cfg(1, 0, 0);
    enable = 1'b1;
    tick();
    span("p1", 2, 1, 0, 8);
    enable = 1'b0;
    span("p1stop", 2, 1, 8, 10);
    end_check("p1end");
    tick();
    quiet("p1q", 4);

    load_cfg(4, 1, 3);
    enable = 1'b1;
    tick();
    span("b3", 4, 1, 0, 12);
    end_check("b3end");
    enable = 1'b0;
    tick();
    quiet("b3q", 8);

    load_cfg(4, 1, 2);
    enable = 1'b1;
    tick();
    span("b2", 4, 1, 0, 7);
    enable = 1'b0;
    span("b2s", 4, 1, 7, 8);
    end_check("b2end");
    tick();
    quiet("b2q", 6);

    for (int r = 0; r < 6; r++) begin
      pr = int'($urandom_range(0, 20));
      hr = int'($urandom_range(0, 24));
      br = int'($urandom_range(1, 4));
      san(pr, hr, ps, hs);
      load_cfg(pr, hr, br);
      enable = 1'b1;
      tick();
      span("rnd", ps, hs, 0, br * ps);
      end_check("rndend");
      enable = 1'b0;
      tick();
      quiet("rndq", 2);
    end

    load_cfg(10, 5, 0);
    enable = 1'b1;
    tick();
    last = -1;
    meas = 0;
    for (int c = 0; c < 110; c++) begin
      if (edge_pulse === 1'b1) begin
        if (last >= 0) meas = c - last;
        last = c;
      end
      tick();
    end
    n_chk++;
    assert (meas == 10) else begin
      n_fail++;
      $error("FAIL freq observed=%0d expected=%0d", meas, 10);
    end

    chk("prerst_out", out_wave, 1'b1);
    #3;
    nReset = 1'b0;
    #1;
    chk("arst_out", out_wave, 1'b0);
    chk("arst_edge", edge_pulse, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", bus.cfg_ready, 1'b1);
    tick();
    nReset = 1'b1;
    tick();
    quiet("postrst", 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_gen.md
# wave_gen

Programmable square-wave generator that produces a test waveform whose period and high time are set in `Clock` cycles. It is the stimulus side of the frequency-measurement path: on the FPGA its `out_wave` feeds the frequency counter's `in_wave`, either looped back for self-calibration or driven into a Superchip sample in place of the chip's own oscillator. A configuration handshake loads new settings, and those settings take effect only at a period boundary, so the output never glitches. An optional burst count stops the output after N periods.

## Interface
- `CNT_W`, 13: width of the period and high-time counters; matches the counter's measurement width.
- `BURST_W`, 8: width of the burst-length field.
- `Clock` in 1: system clock, rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: configuration offered this cycle.
- `cfg_ready` out 1: block can accept a configuration.
- `cfg_period` in CNT_W: period P in Clock cycles.
- `cfg_high` in CNT_W: high time H in Clock cycles.
- `cfg_burst` in BURST_W: number of periods to emit; 0 means continuous.
- `enable` in 1: level; 1 runs the generator, 0 requests a stop.
- `out_wave` out 1: generated waveform, registered.
- `edge_pulse` out 1: one-cycle pulse in the cycle `out_wave` rises.
- `busy` out 1: generator is in a running state.
- `done` out 1: one-cycle pulse when a burst completes or a stop finishes.

## Operation
- Shadow registers hold the pending config (P_s, H_s, B_s) and a `pend` flag. Active registers (P_a, H_a, B_a) drive the counters.
- Handshake: a transfer occurs when `cfg_valid && cfg_ready`. `cfg_ready = !pend`. On transfer the shadow registers load and `pend` is set.
- Sanitising at shadow load:
  - P < 2 is forced to 2.
  - H = 0 is forced to 1.
  - H ≥ P is forced to P−1.
  - The resulting waveform always has at least 1 cycle high and 1 cycle low.
- Shadow-to-active copy clears `pend`. It happens:
  - in IDLE, on any cycle, or
  - in LOW, on the last low cycle (period boundary).
- Counters:
  - `ph_cnt` (CNT_W) counts cycles within the period.
  - `per_cnt` (BURST_W) counts completed periods.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: `out_wave`=0. If `enable` is set and the active config is valid (`cfg_loaded`=1), go to HIGH next cycle, with `ph_cnt`=0 and `per_cnt`=0.
  - HIGH: `out_wave`=1. When `ph_cnt` = H_a−1, go to LOW.
  - LOW: `out_wave`=0. When `ph_cnt` = P_a−1 (the period boundary):
    - increment `per_cnt`;
    - if B_a≠0 and `per_cnt`+1 = B_a, pulse `done` and go to IDLE;
    - else if `enable`=0, pulse `done` and go to IDLE;
    - else apply any pending config, restart `ph_cnt`, and go to HIGH.
- Stops are graceful: deasserting `enable` mid-period completes the current period first.
- `per_cnt` is compared only when B_a≠0. In continuous mode it wraps freely.
- `edge_pulse` is asserted on every IDLE→HIGH and LOW→HIGH transition.

## Timing
- Reset values: `out_wave`=0, `edge_pulse`=0, `done`=0, `busy`=0, `cfg_ready`=1. All counters 0, `pend`=0, `cfg_loaded`=0, state IDLE.
- Start latency: `out_wave` rises on the 1st clock edge after `enable` is sampled high in IDLE with `cfg_loaded`=1.
- Steady state: exactly H_a cycles high, then P_a−H_a cycles low, with no gaps between periods.
- A config accepted at cycle t while running first affects the period that starts after the current period's last low cycle. A config accepted while IDLE is active at the next cycle.
- Simultaneous events:
  - Transfer and boundary in the same cycle: the newly accepted config does not apply at this boundary; it waits for the next one.
  - `enable`=0 and burst end at the same boundary: a single `done` pulse.
- `done` is asserted in the same cycle the state returns to IDLE.
- `busy` = (state ≠ IDLE), registered.
- Asserting `nReset` mid-period forces all reset values immediately (asynchronously), with no final edge. Any pending config is lost.

## Structure
- Shared package `chiptest_pkg`:
  - `wg_state_t` enum {IDLE, HIGH, LOW};
  - `CNT_W` and `BURST_W` defaults;
  - `MIN_PERIOD` = 2.
- A single sub-module, `wg_cfg_shadow`, is natural. It contains the handshake, sanitiser, shadow registers and `pend` flag, and its output is the active-load strobe interface.
- The FSM and counters stay in `wave_gen`.

## Test plan
- Reset, then `cfg` P=10/H=5/B=0, then `enable`=1:
  - `out_wave` first rises 1 cycle after `enable`;
  - steady 5 high / 5 low thereafter;
  - `edge_pulse` every 10 cycles.
- P=1/H=0 offered: sanitised to P=2/H=1, giving a strict alternation 1,0,1,0.
- B=3 with P=4/H=1: exactly 3 rising edges, `done` pulses once on the 12th cycle after start, then `busy`=0.
- While running P=10/H=5, offer P=6/H=2 mid-HIGH:
  - `cfg_ready` drops;
  - the current period completes at 10 cycles;
  - the next period is 2 high / 4 low;
  - `cfg_ready` returns to 1.
- Deassert `enable` 3 cycles into a P=8 period: the period completes (8 cycles total), `done` pulses once, and no further edges occur.
- Loop `out_wave` into the frequency counter with P=10/H=5: its output settles to 10 within 10 periods.
- `nReset` pulsed mid-HIGH: `out_wave` drops to 0 without waiting for a clock edge, and all outputs go to their reset values.
